// File: rtl/if_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_prefetch_queue : instruction prefetcher, one outstanding bus request,   |
// |   DEPTH-entry {inst,pc} FIFO to decode. Option macro: IF_PREFETCH_BYPASS_EN|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module if_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            id_ready_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_inst_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] iaddr_o,
  output logic [XLEN-1:0] idat_o,
  output logic [3:0]      isel_o,
  output logic            icyc_o,
  output logic            istb_o,
  output logic            iwe_o,
  input  logic [XLEN-1:0] idat_i,
  input  logic            iack_i,
  input  logic            ierr_i,
  output logic            fetch_err_o,
  output logic [XLEN-1:0] fault_pc_o
);

  localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HALT} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   fetch_pc_q, iaddr_q, fault_pc_q;
  logic              err_q;
  logic [XLEN-1:0]   inst_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;

  logic              resp, ack_ok, fifo_empty, push, pop, bypass_take, bus_active;
  logic [XLEN-1:0]   redir_pc, pc_next;

  assign resp       = iack_i | ierr_i;
  assign ack_ok     = (state_q == S_REQ) && iack_i && !ierr_i && !redirect_i;
  assign fifo_empty = (count_q == '0);
  assign redir_pc   = redirect_pc_i & ~XLEN'(3);
  assign pc_next    = fetch_pc_q + XLEN'(4);

`ifdef IF_PREFETCH_BYPASS_EN
  logic byp_ok;
  // An ack into an empty queue is offered to decode in the same cycle.
  assign byp_ok      = ack_ok && fifo_empty;
  assign bypass_take = byp_ok && id_ready_i;
  assign id_valid_o  = !fifo_empty || byp_ok;
  assign id_inst_o   = !fifo_empty ? inst_mem[rptr_q] : (byp_ok ? idat_i  : '0);
  assign id_pc_o     = !fifo_empty ? pc_mem[rptr_q]   : (byp_ok ? iaddr_q : '0);
`else
  assign bypass_take = 1'b0;
  assign id_valid_o  = !fifo_empty;
  assign id_inst_o   = fifo_empty ? '0 : inst_mem[rptr_q];
  assign id_pc_o     = fifo_empty ? '0 : pc_mem[rptr_q];
`endif

  assign push    = ack_ok && !bypass_take;
  assign pop     = !fifo_empty && id_ready_i && !redirect_i;
  assign count_d = count_q + CW'(push) - CW'(pop);

  assign bus_active  = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign icyc_o      = bus_active;
  assign istb_o      = bus_active;
  assign isel_o      = bus_active ? 4'hF : 4'h0;
  assign iaddr_o     = iaddr_q;
  assign idat_o      = '0;
  assign iwe_o       = 1'b0;
  assign fetch_err_o = err_q;
  assign fault_pc_o  = fault_pc_q;

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr_q] <= idat_i;
      pc_mem[wptr_q]   <= iaddr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (redirect_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      iaddr_q    <= '0;
      err_q      <= 1'b0;
      fault_pc_q <= '0;
    end else if (redirect_i) begin
      fetch_pc_q <= redir_pc;
      err_q      <= 1'b0;
      // An unanswered request must be drained so its response is not mistaken for the new PC.
      if (bus_active && !resp) begin
        state_q <= S_DRAIN;
      end else begin
        state_q <= S_REQ;
        iaddr_q <= redir_pc;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q < FULL) begin
            state_q <= S_REQ;
            iaddr_q <= fetch_pc_q;
          end
        end
        S_REQ: begin
          if (ierr_i) begin
            err_q      <= 1'b1;
            fault_pc_q <= iaddr_q;
            state_q    <= S_HALT;
          end else if (iack_i) begin
            fetch_pc_q <= pc_next;
            if (count_d < FULL) begin
              state_q <= S_REQ;
              iaddr_q <= pc_next;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (resp) begin
            state_q <= S_REQ;
            iaddr_q <= fetch_pc_q;
          end
        end
        S_HALT:  ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// Self-checking bench for if_prefetch_queue: bus memory model plus a
// scoreboard of words that decode must receive, in order.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_ready_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_inst_o, id_pc_o, iaddr_o, idat_o, fault_pc_o;
  logic [3:0]  isel_o;
  logic        icyc_o, istb_o, iwe_o, fetch_err_o;
  logic [31:0] idat_i = '0;
  logic        iack_i = 1'b0;
  logic        ierr_i = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;

  int          lat = 1;
  bit          mem_en = 1'b1;
  bit          word_mode = 1'b0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          wcnt = 0;
  bit          had_resp, stb_prev = 1'b0;
  bit          orphan = 1'b0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] addr_log[$];
  logic [31:0] pop_log[$];

  if_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_ready_i(id_ready_i), .id_valid_o(id_valid_o),
    .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
    .iaddr_o(iaddr_o), .idat_o(idat_o), .isel_o(isel_o),
    .icyc_o(icyc_o), .istb_o(istb_o), .iwe_o(iwe_o),
    .idat_i(idat_i), .iack_i(iack_i), .ierr_i(ierr_i),
    .fetch_err_o(fetch_err_o), .fault_pc_o(fault_pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return word_mode ? ({a[23:0], 8'h13} ^ 32'h5A00_0000) : 32'h0000_0013;
  endfunction

  // Memory: answers each strobe after `lat` wait cycles; records launches and
  // queues the words decode is expected to see.
  always @(posedge clk) begin
    #1;
    had_resp = iack_i | ierr_i;
    iack_i = 1'b0;
    ierr_i = 1'b0;
    if (had_resp || !istb_o) wcnt = 0;
    if (istb_o && (had_resp || !stb_prev)) addr_log.push_back(iaddr_o);
    stb_prev = istb_o;
    if (istb_o && mem_en) begin
      if (wcnt >= lat) begin
        if (err_en && iaddr_o == err_addr) ierr_i = 1'b1;
        else begin
          iack_i = 1'b1;
          idat_i = mem_word(iaddr_o);
        end
        if (orphan) orphan = 1'b0;
        else if (iack_i) begin
          exp_pc_q.push_back(iaddr_o);
          exp_inst_q.push_back(idat_i);
        end
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Decode side: compares every accepted word against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (redirect_i) begin
        exp_pc_q.delete();
        exp_inst_q.delete();
        if (istb_o && !(iack_i || ierr_i)) orphan = 1'b1;
      end else if (id_valid_o && id_ready_i) begin
        check("sb_avail", 32'(exp_pc_q.size() != 0), 32'd1);
        if (exp_pc_q.size() != 0) begin
          check("sb_pc", id_pc_o, exp_pc_q.pop_front());
          check("sb_inst", id_inst_o, exp_inst_q.pop_front());
        end
        pop_log.push_back(id_pc_o);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect_i = 1'b0;
    repeat (2) @(negedge clk);
    exp_pc_q.delete();
    exp_inst_q.delete();
    addr_log.delete();
    pop_log.delete();
    orphan = 1'b0;
    rst = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_i = 1'b1;
    redirect_pc_i = pc;
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;

    repeat (2) @(negedge clk);
    check("rst_valid", id_valid_o, 0);
    check("rst_inst", id_inst_o, 0);
    check("rst_pc", id_pc_o, 0);
    check("rst_cyc", {icyc_o, istb_o, iwe_o}, 0);
    check("rst_addr", iaddr_o, 0);
    check("rst_sel", isel_o, 0);
    check("rst_err", fetch_err_o, 0);
    check("rst_fpc", fault_pc_o, 0);

    // 1: sequential streaming
    lat = 1; id_ready_i = 1'b1; word_mode = 1'b0;
    apply_reset();
    for (int k = 0; k < 60 && !id_valid_o; k++) @(negedge clk);
    check("t1_sel", isel_o, 4'hF);
    check("t1_inst", id_inst_o, 32'h13);
    for (int k = 0; k < 60 && pop_log.size() < 3; k++) @(negedge clk);
    check("t1_to", 32'(pop_log.size() >= 3), 1);
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", addr_log[i], 32'(4 * i));
      check("t1_pop", pop_log[i], 32'(4 * i));
    end

    // 2: stall fills the queue, then drain and resume
    word_mode = 1'b1; id_ready_i = 1'b0;
    apply_reset();
    repeat (20) @(negedge clk);
    check("t2_nreq", 32'(addr_log.size()), 4);
    check("t2_cyc", icyc_o, 0);
    check("t2_valid", id_valid_o, 1);
    check("t2_head", id_pc_o, 0);
    id_ready_i = 1'b1;
    for (int k = 0; k < 60 && (pop_log.size() < 4 || addr_log.size() < 5); k++) @(negedge clk);
    check("t2_to", 32'(pop_log.size() >= 4 && addr_log.size() >= 5), 1);
    for (int i = 0; i < 4; i++) check("t2_pop", pop_log[i], 32'(4 * i));
    check("t2_resume", addr_log[4], 32'h10);

    // 3: redirect with an outstanding request, then a misaligned redirect
    lat = 3;
    apply_reset();
    for (int k = 0; k < 80 && !(istb_o && iaddr_o == 32'h8); k++) @(negedge clk);
    check("t3_to_req", 32'(istb_o && iaddr_o == 32'h8), 1);
    n = pop_log.size();
    redirect_to(32'h100);
    check("t3_drain", {31'd0, icyc_o} | 32'(iaddr_o != 32'h8), 1);
    check("t3_drain_addr", iaddr_o, 32'h8);
    for (int k = 0; k < 80 && pop_log.size() <= n; k++) @(negedge clk);
    check("t3_to_pop", 32'(pop_log.size() > n), 1);
    check("t3_newpc", pop_log[n], 32'h100);
    n = pop_log.size();
    redirect_to(32'h103);
    for (int k = 0; k < 80 && pop_log.size() <= n; k++) @(negedge clk);
    check("t3_to_pop2", 32'(pop_log.size() > n), 1);
    check("t3_align", pop_log[n], 32'h100);

    // 4: bus error halts fetch; queued words still drain
    lat = 1; id_ready_i = 1'b0; err_en = 1'b1; err_addr = 32'hC;
    apply_reset();
    for (int k = 0; k < 60 && !fetch_err_o; k++) @(negedge clk);
    check("t4_err", fetch_err_o, 1);
    check("t4_fpc", fault_pc_o, 32'hC);
    repeat (2) @(negedge clk);
    check("t4_idle", icyc_o, 0);
    id_ready_i = 1'b1;
    for (int k = 0; k < 40 && pop_log.size() < 3; k++) @(negedge clk);
    check("t4_to", 32'(pop_log.size() >= 3), 1);
    for (int i = 0; i < 3; i++) check("t4_pop", pop_log[i], 32'(4 * i));
    repeat (2) @(negedge clk);
    check("t4_empty", id_valid_o, 0);
    check("t4_halt", icyc_o, 0);
    err_en = 1'b0;
    n = pop_log.size();
    redirect_to(32'h40);
    check("t4_clr", fetch_err_o, 0);
    check("t4_req", icyc_o, 1);
    check("t4_addr", iaddr_o, 32'h40);
    for (int k = 0; k < 40 && pop_log.size() <= n; k++) @(negedge clk);
    check("t4_to_pop", 32'(pop_log.size() > n), 1);
    check("t4_newpc", pop_log[n], 32'h40);

    // 5: asynchronous reset in the middle of a request
    id_ready_i = 1'b0;
    apply_reset();
    for (int k = 0; k < 40 && !(id_valid_o && istb_o); k++) @(negedge clk);
    check("t5_to", 32'(id_valid_o && istb_o), 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t5_cyc", icyc_o, 0);
    check("t5_valid", id_valid_o, 0);
    check("t5_addr", iaddr_o, 0);
    @(negedge clk);
    exp_pc_q.delete();
    exp_inst_q.delete();
    addr_log.delete();
    pop_log.delete();
    orphan = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 20 && addr_log.size() < 1; k++) @(negedge clk);
    check("t5_to_req", 32'(addr_log.size() >= 1), 1);
    check("t5_first", addr_log[0], 32'h0);

    // 6: first word latency into an empty queue
    id_ready_i = 1'b1;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2;
      if (iack_i) break;
    end
    check("t6_to", iack_i, 1);
    a = iaddr_o;
`ifdef IF_PREFETCH_BYPASS_EN
    check("t6_byp_valid", id_valid_o, 1);
    check("t6_byp_pc", id_pc_o, a);
    @(posedge clk);
    #2;
    check("t6_no_push", id_valid_o, 0);
`else
    check("t6_lat_valid", id_valid_o, 0);
    @(posedge clk);
    #2;
    check("t6_lat_valid1", id_valid_o, 1);
    check("t6_lat_pc", id_pc_o, a);
`endif
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
